fsk_phase_discriminator: RTL and testbench

Downstream consumer of the `cordic_vector` stage in the demodulator chain. It takes the per-sample phase angle (unsigned degrees, 0..359) and its completion strobe, and differentiates successive angles with ±180° wrap to get instantaneous frequency deviation. It integrates that deviation over one symbol period and issues a hard bit decision per symbol to the bit-sync/framing logic.

---
 rtl/fsk_phase_discriminator.sv | 171 +++++++++++++++++
 tb/tb_fsk_phase_discriminator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_phase_discriminator.sv
// -----------------------------------------------------------------------------
// fsk_phase_discriminator
//
// This block turns the per-sample phase angle from cordic_vector into
// instantaneous frequency deviation. It subtracts successive angles and wraps
// the result into -180..+179. It integrates the deviation over one symbol in a
// saturating signed accumulator, then makes one hard bit decision per symbol.
//
// Handshake: there is no ready/backpressure anywhere. Each *_valid or *_sync
// input is a one-cycle strobe, and the block accepts it on the rising edge
// where it is high. Each *_valid output is a one-cycle strobe that qualifies
// its data output, and that data output is registered alongside it. Back-to-
// back input strobes are all processed.
//
// Parameters
//   SAMPLES_PER_SYMBOL  deltas integrated per bit decision (2..255)
//   ACC_W               signed accumulator width (saturating)
//   THRESH              signed decision threshold, bit_out = (sum > THRESH)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, overrides all inputs
//   angle_in     unsigned phase in degrees, legal 0..359
//   angle_valid  strobe qualifying angle_in
//   sym_sync     strobe restarting symbol integration
//   delta_out    signed wrapped phase difference, -180..+179
//   delta_valid  strobe qualifying delta_out / acc_out
//   acc_out      accumulator after the update of this sample
//   bit_out      symbol decision, held between decisions
//   bit_valid    strobe qualifying bit_out
//   err          sticky flag: an angle >= 360 was received
//   state_dbg    current FSM state (0 = EMPTY, 1 = PRIMED)
// -----------------------------------------------------------------------------
module fsk_phase_discriminator #(
   parameter int        SAMPLES_PER_SYMBOL = 8,
   parameter int        ACC_W              = 16,
   parameter int signed THRESH             = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8:0]              angle_in,
   input  logic                    angle_valid,
   input  logic                    sym_sync,
   output logic signed [9:0]       delta_out,
   output logic                    delta_valid,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic                    err,
   output logic                    state_dbg
);

   typedef enum logic {
      EMPTY  = 1'b0,
      PRIMED = 1'b1
   } state_t;

   // The sum is formed at a width that holds any acc + delta without overflow.
   // Deltas need 11 bits, so the width is at least 11 + 1 even for narrow
   // accumulators.
   localparam int SW = ((ACC_W > 11) ? ACC_W : 11) + 1;

   localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic signed [SW-1:0] THR_W   = SW'(THRESH);
   localparam logic [8:0]           SPS_L   = 9'(SAMPLES_PER_SYMBOL);

   state_t                  state;
   logic [8:0]              prev;
   logic signed [ACC_W-1:0] acc;
   logic [7:0]              cnt;

   logic                    legal;
   logic signed [10:0]      d_raw;
   logic signed [10:0]      d_wrap;
   logic signed [SW-1:0]    acc_base;
   logic signed [SW-1:0]    sum_w;
   logic signed [SW-1:0]    sat_w;
   logic [8:0]              cnt_next;
   logic                    last;

   assign state_dbg = state;

   always_comb begin
      legal = (angle_in < 9'd360);

      // Angle difference with wrap into -180..+179. A difference of exactly
      // +180 takes the "> 179" branch, so it comes out as -180.
      d_raw = $signed({2'b00, angle_in}) - $signed({2'b00, prev});
      if (d_raw > 11'sd179) begin
         d_wrap = d_raw - 11'sd360;
      end else if (d_raw < -11'sd180) begin
         d_wrap = d_raw + 11'sd360;
      end else begin
         d_wrap = d_raw;
      end

      // A coincident sym_sync clears first, so this sample's delta becomes
      // the first term of the new symbol.
      if (sym_sync) begin
         acc_base = '0;
         cnt_next = 9'd1;
      end else begin
         acc_base = {{(SW-ACC_W){acc[ACC_W-1]}}, acc};
         cnt_next = {1'b0, cnt} + 9'd1;
      end

      sum_w = acc_base + {{(SW-11){d_wrap[10]}}, d_wrap};
      if (sum_w > ACC_MAX) begin
         sat_w = ACC_MAX;
      end else if (sum_w < ACC_MIN) begin
         sat_w = ACC_MIN;
      end else begin
         sat_w = sum_w;
      end

      last = (cnt_next == SPS_L);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         prev        <= '0;
         acc         <= '0;
         cnt         <= '0;
         delta_out   <= '0;
         delta_valid <= 1'b0;
         acc_out     <= '0;
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         err         <= 1'b0;
      end else begin
         delta_valid <= 1'b0;
         bit_valid   <= 1'b0;

         // The restart applies whatever else happens this cycle. The PRIMED
         // sample path below overrides these with the new first term.
         if (sym_sync) begin
            acc     <= '0;
            cnt     <= '0;
            acc_out <= '0;
         end

         if (angle_valid) begin
            if (!legal) begin
               // Drop the sample and re-prime. The partial sum is kept.
               err   <= 1'b1;
               state <= EMPTY;
            end else if (state == EMPTY) begin
               prev  <= angle_in;
               state <= PRIMED;
            end else begin
               prev        <= angle_in;
               delta_out   <= d_wrap[9:0];
               delta_valid <= 1'b1;
               acc_out     <= sat_w[ACC_W-1:0];
               if (last) begin
                  bit_out   <= (sat_w > THR_W);
                  bit_valid <= 1'b1;
                  acc       <= '0;
                  cnt       <= '0;
               end else begin
                  acc <= sat_w[ACC_W-1:0];
                  cnt <= cnt_next[7:0];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fsk_phase_discriminator.sv
// -----------------------------------------------------------------------------
// tb_fsk_phase_discriminator
//
// Two instances share one input stream. Instance 0 uses SAMPLES_PER_SYMBOL=4
// and ACC_W=16. Instance 1 uses SAMPLES_PER_SYMBOL=8 and ACC_W=8, which
// exercises saturation. A reference model works in plain integers. It wraps
// the delta with modular arithmetic, ((a - p + 540) mod 360) - 180, and
// predicts every registered output after each edge. The directed sections
// follow the block's intended use cases. A randomized section follows them.
// -----------------------------------------------------------------------------
module tb_fsk_phase_discriminator;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [8:0]  angle_in;
   logic        angle_valid;
   logic        sym_sync;

   logic signed [9:0]  delta_o [2];
   logic               dv_o    [2];
   logic               bit_o   [2];
   logic               bv_o    [2];
   logic               err_o   [2];
   logic               st_o    [2];
   logic signed [15:0] acc_a;
   logic signed [7:0]  acc_b;

   fsk_phase_discriminator #(
      .SAMPLES_PER_SYMBOL (4),
      .ACC_W              (16),
      .THRESH             (0)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .angle_in    (angle_in),
      .angle_valid (angle_valid),
      .sym_sync    (sym_sync),
      .delta_out   (delta_o[0]),
      .delta_valid (dv_o[0]),
      .acc_out     (acc_a),
      .bit_out     (bit_o[0]),
      .bit_valid   (bv_o[0]),
      .err         (err_o[0]),
      .state_dbg   (st_o[0])
   );

   fsk_phase_discriminator #(
      .SAMPLES_PER_SYMBOL (8),
      .ACC_W              (8),
      .THRESH             (0)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .angle_in    (angle_in),
      .angle_valid (angle_valid),
      .sym_sync    (sym_sync),
      .delta_out   (delta_o[1]),
      .delta_valid (dv_o[1]),
      .acc_out     (acc_b),
      .bit_out     (bit_o[1]),
      .bit_valid   (bv_o[1]),
      .err         (err_o[1]),
      .state_dbg   (st_o[1])
   );

   // ---------------- reference model ----------------
   int sps  [2] = '{4, 8};
   int amax [2] = '{32767, 127};
   int amin [2] = '{-32768, -128};

   int m_primed [2];
   int m_prev   [2];
   int m_acc    [2];
   int m_cnt    [2];
   int e_dv     [2];
   int e_delta  [2];
   int e_acc    [2];
   int e_bit    [2];
   int e_bv     [2];
   int e_err    [2];

   int checks = 0;
   int errors = 0;

   task automatic model_step(input int r, input int a, input int v, input int s);
      int d;
      int sum;
      for (int i = 0; i < 2; i++) begin
         e_dv[i] = 0;
         e_bv[i] = 0;
         if (r != 0) begin
            m_primed[i] = 0; m_prev[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
            e_delta[i] = 0; e_acc[i] = 0; e_bit[i] = 0; e_err[i] = 0;
         end else begin
            if (s != 0) begin
               m_acc[i] = 0;
               m_cnt[i] = 0;
            end
            if (v != 0) begin
               if (a >= 360) begin
                  e_err[i]    = 1;
                  m_primed[i] = 0;
               end else if (m_primed[i] == 0) begin
                  m_prev[i]   = a;
                  m_primed[i] = 1;
               end else begin
                  d = ((a - m_prev[i] + 540) % 360) - 180;
                  m_prev[i] = a;
                  sum = m_acc[i] + d;
                  if (sum > amax[i]) sum = amax[i];
                  if (sum < amin[i]) sum = amin[i];
                  m_cnt[i]   = m_cnt[i] + 1;
                  e_dv[i]    = 1;
                  e_delta[i] = d;
                  e_acc[i]   = sum;
                  if (m_cnt[i] == sps[i]) begin
                     e_bv[i]  = 1;
                     e_bit[i] = (sum > 0) ? 1 : 0;
                     m_acc[i] = 0;
                     m_cnt[i] = 0;
                  end else begin
                     m_acc[i] = sum;
                  end
               end
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string sec);
      logic signed [31:0] acc_obs;
      for (int i = 0; i < 2; i++) begin
         acc_obs = (i == 0) ? 32'(acc_a) : 32'(acc_b);
         chk($sformatf("%s.u%0d.delta_valid", sec, i), 32'(dv_o[i]), e_dv[i]);
         chk($sformatf("%s.u%0d.bit_valid",   sec, i), 32'(bv_o[i]), e_bv[i]);
         chk($sformatf("%s.u%0d.bit_out",     sec, i), 32'(bit_o[i]), e_bit[i]);
         chk($sformatf("%s.u%0d.err",         sec, i), 32'(err_o[i]), e_err[i]);
         if (e_dv[i] != 0) begin
            chk($sformatf("%s.u%0d.delta_out", sec, i), 32'(delta_o[i]), e_delta[i]);
            chk($sformatf("%s.u%0d.acc_out",   sec, i), acc_obs, e_acc[i]);
         end
      end
   endtask

   // ---------------- driver ----------------
   string cur_sec = "init";

   task automatic cyc(input int r, input int a, input int v, input int s);
      logic [8:0] a9;
      a9          = a[8:0];
      rst         = r[0];
      angle_in    = a9;
      angle_valid = v[0];
      sym_sync    = s[0];
      @(posedge clk);
      model_step(r, a, v, s);
      #1;
      compare_all(cur_sec);
   endtask

   task automatic strobe_gap(input int a, input int gap);
      cyc(0, a, 1, 0);
      for (int k = 0; k < gap; k++) cyc(0, 0, 0, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; angle_in = '0; angle_valid = 1'b0; sym_sync = 1'b0;

      // Reset state
      cur_sec = "reset";
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("reset.delta_out", 32'(delta_o[0]), 0);
      chk("reset.acc_out", 32'(acc_a), 0);
      chk("reset.err", 32'(err_o[0]), 0);

      // Basic symbol: ascending then descending, one strobe every 3 cycles
      cur_sec = "basic";
      cyc(0, 0, 1, 0);
      chk("basic.prime_no_dv", 32'(dv_o[0]), 0);
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(0, k * 10, 1, 0);
         chk($sformatf("basic.up.delta%0d", k), 32'(delta_o[0]), 10);
         chk($sformatf("basic.up.acc%0d", k), 32'(acc_a), k * 10);
         cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      end
      chk("basic.up.bit", 32'(bit_o[0]), 1);
      for (int k = 3; k >= 0; k--) strobe_gap(k * 10, 2);
      chk("basic.down.bit", 32'(bit_o[0]), 0);

      // Wrap cases
      cur_sec = "wrap";
      cyc(0, 350, 1, 0); cyc(0, 10, 1, 0);
      chk("wrap.350_10", 32'(delta_o[0]), 20);
      cyc(0, 350, 1, 0);
      chk("wrap.10_350", 32'(delta_o[0]), -20);
      cyc(0, 0, 1, 0); cyc(0, 180, 1, 0);
      chk("wrap.0_180", 32'(delta_o[0]), -180);
      cyc(0, 0, 1, 0);
      chk("wrap.180_0", 32'(delta_o[0]), -180);
      cyc(0, 359, 1, 0); cyc(0, 0, 1, 0);
      chk("wrap.359_0", 32'(delta_o[0]), 1);

      // Illegal angle
      cur_sec = "illegal";
      cyc(1, 0, 0, 0);
      strobe_gap(100, 1); strobe_gap(110, 1);
      cyc(0, 400, 1, 0);
      chk("illegal.err_rise", 32'(err_o[0]), 1);
      chk("illegal.no_dv_400", 32'(dv_o[0]), 0);
      cyc(0, 0, 0, 0);
      cyc(0, 120, 1, 0);
      chk("illegal.no_dv_reprime", 32'(dv_o[0]), 0);
      cyc(0, 0, 0, 0);
      cyc(0, 130, 1, 0);
      chk("illegal.delta_after", 32'(delta_o[0]), 10);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
      chk("illegal.err_sticky", 32'(err_o[0]), 1);

      // sym_sync mid-symbol and coincident with a sample
      cur_sec = "sync";
      cyc(1, 0, 0, 0);
      strobe_gap(0, 1); strobe_gap(10, 1); strobe_gap(20, 1);
      chk("sync.acc_before", 32'(acc_a), 20);
      cyc(0, 0, 0, 1);
      strobe_gap(30, 1);
      strobe_gap(40, 1);
      chk("sync.no_bv_at_2", 32'(bv_o[0]), 0);
      strobe_gap(50, 1);
      cyc(0, 60, 1, 0);
      chk("sync.bv_at_4", 32'(bv_o[0]), 1);
      cyc(0, 0, 0, 0);
      strobe_gap(70, 1);
      cyc(0, 80, 1, 1);
      chk("sync.coincident_acc", 32'(acc_a), 10);
      cyc(0, 0, 0, 0);

      // Saturation on the 8-bit instance
      cur_sec = "sat";
      cyc(1, 0, 0, 0);
      for (int k = 0; k <= 8; k++) cyc(0, (k * 90) % 360, 1, 0);
      chk("sat.pos_clamp", 32'(acc_b), 127);
      chk("sat.pos_bit", 32'(bit_o[1]), 1);
      for (int k = 1; k <= 8; k++) cyc(0, (720 - k * 90) % 360, 1, 0);
      chk("sat.neg_clamp", 32'(acc_b), -128);
      chk("sat.neg_bit", 32'(bit_o[1]), 0);

      // Back-to-back strobes and reset mid-symbol
      cur_sec = "b2b";
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 6; k++) cyc(0, k * 25, 1, 0);
      chk("b2b.dv_consecutive", 32'(dv_o[0]), 1);
      cyc(1, 200, 1, 1);
      chk("b2b.rst_acc", 32'(acc_a), 0);
      chk("b2b.rst_dv", 32'(dv_o[0]), 0);
      cyc(0, 40, 1, 0);
      chk("b2b.post_rst_prime", 32'(dv_o[0]), 0);
      cyc(0, 50, 1, 0);

      // Randomized traffic against the model
      cur_sec = "rand";
      for (int n = 0; n < 600; n++) begin
         int r, a, v, s;
         r = ($urandom_range(0, 99) < 1) ? 1 : 0;
         v = ($urandom_range(0, 99) < 60) ? 1 : 0;
         s = ($urandom_range(0, 99) < 5) ? 1 : 0;
         a = ($urandom_range(0, 99) < 4) ? int'($urandom_range(360, 511))
                                         : int'($urandom_range(0, 359));
         cyc(r, a, v, s);
      end
      cyc(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
